// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// default boot address and the exception word bit positions used by the
// pipeline when it reports a fetch/decode fault.
package if_stage_pkg;

   // REQ    : presenting the PC on the instruction bus
   // WAIT   : address accepted, waiting for the read data
   // HOLD   : instruction captured and presented to decode
   // CANCEL : a flushed request is still in flight; swallow its data
   typedef enum logic [1:0] {
      ST_REQ    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_HOLD   = 2'd2,
      ST_CANCEL = 2'd3
   } if_state_t;

   // MIPS boot vector (kseg1, uncached)
   localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   // Bit positions inside the 32-bit exception word
   localparam int EXC_SYSCALL = 8;
   localparam int EXC_INVALID = 9;
   localparam int EXC_ERET    = 12;
   localparam int EXC_ADEL_IF = 13;

   function automatic logic [31:0] exc_mask(input int bit_idx);
      return 32'h1 << bit_idx;
   endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one bus read at a time and presents the result to decode.
// Latency: data_ok to valid_o is one cycle; a misaligned PC yields an AdEL slot one cycle later.
// Backpressure: stall_i holds the presented instruction in HOLD; it never blocks a bus request.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall_i                  decode cannot take the presented instruction
//   flush_i, new_pc_i        redirect (exception/eret); highest priority
//   branch_flag_i,
//   branch_to_addr_i         taken branch/jump currently in decode and its target
//   inst_req_o, inst_addr_o  instruction bus request
//   inst_addr_ok_i           request accepted this cycle
//   inst_data_ok_i,
//   inst_rdata_i             read data returned this cycle
//   valid_o, pc_o, inst_o,
//   is_in_delayslot_o,
//   exception_o              fetched slot towards the decode pipeline register
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_to_addr_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_addr_ok_i,
   input  logic        inst_data_ok_i,
   input  logic [31:0] inst_rdata_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] exception_o
);

   if_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        adel_q, adel_d;

   logic        pc_aligned;
   logic        req_fire;
   logic [31:0] next_pc;

   assign pc_aligned = (pc_q[1:0] == 2'b00);

   // Gated by rst so the bus sees no request while the core is held in reset.
   assign inst_req_o  = (state_q == ST_REQ) && pc_aligned && !rst;
   assign inst_addr_o = pc_q;
   assign req_fire    = inst_req_o && inst_addr_ok_i;

   // Next-PC mux used at handover; the +4 wraps naturally at 2^32.
   assign next_pc = branch_flag_i ? branch_to_addr_i : (pc_q + 32'd4);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      adel_d  = adel_q;

      case (state_q)
         ST_REQ: begin
            if (flush_i) begin
               pc_d = new_pc_i;
               // An accepted request cannot be withdrawn; its data must be swallowed.
               state_d = req_fire ? ST_CANCEL : ST_REQ;
            end else if (!pc_aligned) begin
               // No bus cycle: present a null instruction tagged with AdEL.
               inst_d  = '0;
               adel_d  = 1'b1;
               state_d = ST_HOLD;
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (flush_i) begin
               pc_d = new_pc_i;
               // Data arriving together with the flush closes the transaction.
               state_d = inst_data_ok_i ? ST_REQ : ST_CANCEL;
            end else if (inst_data_ok_i) begin
               inst_d  = inst_rdata_i;
               adel_d  = 1'b0;
               state_d = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (flush_i) begin
               pc_d    = new_pc_i;
               state_d = ST_REQ;
            end else if (!stall_i) begin
               pc_d    = next_pc;
               state_d = ST_REQ;
            end
         end

         ST_CANCEL: begin
            if (flush_i) begin
               pc_d = new_pc_i;
            end
            // The in-flight read is over once its data shows up, flushed again or not.
            if (inst_data_ok_i) begin
               state_d = ST_REQ;
            end
         end

         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         adel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         adel_q  <= adel_d;
      end
   end

   assign valid_o           = (state_q == ST_HOLD);
   assign pc_o              = pc_q;
   assign inst_o            = inst_q;
   assign exception_o       = adel_q ? exc_mask(EXC_ADEL_IF) : 32'h0;
   assign is_in_delayslot_o = valid_o && branch_flag_i;

endmodule
